uart_rx_word_packer: RTL

//  Front-end stage of the UART MVM system: receives 8N1 UART frames on rx,

---
 rtl/uart_rx_word_packer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_word_packer.sv
// UART 8N1 receiver that samples each bit mid-period and packs N_WORDS bytes
// into one W_BUS-wide word offered on a valid/ready stream.
module uart_rx_word_packer #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_BUS            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [W_BUS-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_err,
    output logic             overflow,
    output logic             busy
);

    localparam int N_WORDS = W_BUS / BITS_PER_WORD;
    localparam int CW      = $clog2(CLOCKS_PER_PULSE);
    localparam int BW      = $clog2(BITS_PER_WORD);
    localparam int NW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_WORD - 1);
    localparam logic [NW-1:0] WORD_LAST = NW'(N_WORDS - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic [NW-1:0]          word_cnt_q, word_cnt_d;
    logic [W_BUS-1:0]       asm_q, asm_d;
    logic [W_BUS-1:0]       m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;
    logic                   rx_meta_q, rxs_q;
    logic                   byte_done;
    logic [W_BUS-1:0]       asm_next;

    // rx is asynchronous; both synchronizer stages reset to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            word_cnt_q  <= '0;
            asm_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            word_cnt_q  <= word_cnt_d;
            asm_q       <= asm_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                if (!rxs_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[BITS_PER_WORD-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d   = IDLE;
                        byte_done = 1'b1;
                    end else begin
                        state_d     = WAIT_IDLE;
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // asm_next already contains the byte just received, so a completed word
    // can move to the output in the same cycle its last stop bit is sampled
    always_comb begin
        asm_next = asm_q;
        for (int i = 0; i < N_WORDS; i++) begin
            if (word_cnt_q == NW'(i)) begin
                asm_next[i*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
            end
        end

        asm_d      = asm_q;
        word_cnt_d = word_cnt_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        overflow_d = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (byte_done) begin
            asm_d = asm_next;
            if (word_cnt_q == WORD_LAST) begin
                word_cnt_d = '0;
                if (!m_valid_q || m_ready) begin
                    m_data_d  = asm_next;
                    m_valid_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                word_cnt_d = word_cnt_q + NW'(1);
            end
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE);

endmodule
